// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_pkg: types and helpers shared by the keypad scanner and its event FIFO.
//   scan_state_t    - scan sequencer states
//   key_event_t     - queued key event {code, press}; code is MAX_KW wide and
//                     zero-extended from the scanner's KW-bit key code
//   debounce_cnt_w  - width of a per-key debounce counter
package keypad_pkg;

  typedef enum logic [1:0] {WAIT, SAMPLE, COMMIT, ADVANCE} scan_state_t;

  // Widest key code an event can carry (up to 256 keys).
  localparam int MAX_KW = 8;

  typedef struct packed {
    logic [MAX_KW-1:0] code;
    logic              press;
  } key_event_t;

  // The counter must be able to hold DEBOUNCE-1 and compare against it.
  function automatic int debounce_cnt_w(input int debounce);
    return (debounce < 2) ? 1 : $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: first-word-fall-through FIFO for key events.
//   clock, reset      - clock and synchronous active-high reset
//   push, push_data   - write request and data (ignored when full unless popping)
//   pop               - read request (ignored when empty)
//   head              - head entry; holds the last popped entry while empty
//   full, empty       - occupancy flags
module keypad_event_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] last_q;
  logic             pop_en;
  logic             push_en;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_en  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign head    = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-at-a-time matrix keypad scanner with per-key
// debounce and an event FIFO.
//   clock, reset   - clock and synchronous active-high reset
//   row            - one-hot active-high row drive
//   col            - active-high column sense (already synchronised)
//   key_valid      - an event is presented; key_ready accepts it
//   key_code       - event key code = row_index*COLS + col_index
//   key_press      - event type, 1 = press, 0 = release
//   key_state      - debounced state bitmap, bit k = code k
//   overflow       - sticky dropped-event flag; overflow_clr clears it
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 10000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int KW        = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1,
  localparam int FRAME     = ROWS*SCAN_DIV
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [ROWS-1:0]      row,
  input  logic [COLS-1:0]      col,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [KW-1:0]        key_code,
  output logic                 key_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int NK  = ROWS*COLS;
  localparam int CW  = debounce_cnt_w(DEBOUNCE);
  localparam int TW  = $clog2(SCAN_DIV);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  scan_state_t     state;
  logic [RW-1:0]   r;
  logic [CLW-1:0]  c;
  logic [COLS-1:0] col_p0;
  logic [CW-1:0]   cnt [NK];
  logic [KW-1:0]   k_cur;
  logic            smp;
  logic            differs;
  logic            settle;
  logic            push_vld;
  key_event_t      push_ev;
  key_event_t      head_ev;
  logic            fifo_full;
  logic            fifo_empty;
  logic            dropped;
  logic            unused_head_hi;

  // Scan tick: one pulse every SCAN_DIV cycles
  assign tick = (tick_cnt == TW'(SCAN_DIV-1));

  always_ff @(posedge clock) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Sequencer: sample the driven row, commit one column per cycle, advance.
  // ADVANCE goes straight to SAMPLE if a tick lands there, so SCAN_DIV = COLS+2
  // still keeps up.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT;
      r     <= '0;
      c     <= '0;
      row   <= ROWS'(1);
    end else begin
      case (state)
        WAIT:    if (tick) state <= SAMPLE;
        SAMPLE: begin
          c     <= '0;
          state <= COMMIT;
        end
        COMMIT: begin
          if (c == CLW'(COLS-1)) state <= ADVANCE;
          else                   c     <= c + 1'b1;
        end
        ADVANCE: begin
          r     <= (r == RW'(ROWS-1)) ? '0 : r + 1'b1;
          row   <= {row[ROWS-2:0], row[ROWS-1]};
          state <= tick ? SAMPLE : WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end

  // Stage p0: column snapshot for the current row
  always_ff @(posedge clock) begin
    if (state == SAMPLE) col_p0 <= col;
  end

  always_comb begin
    k_cur    = KW'(int'(r) * COLS + int'(c));
    smp      = col_p0[c];
    differs  = (smp != key_state[k_cur]);
    settle   = differs && (cnt[k_cur] == CW'(DEBOUNCE-1));
    push_vld = (state == COMMIT) && settle;
    push_ev       = '0;
    push_ev.code  = MAX_KW'(k_cur);
    push_ev.press = smp;
  end

  // Debounce: a key flips only after DEBOUNCE consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      key_state <= '0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else if (state == COMMIT) begin
      if (!differs) begin
        cnt[k_cur] <= '0;
      end else if (settle) begin
        cnt[k_cur]       <= '0;
        key_state[k_cur] <= smp;
      end else begin
        cnt[k_cur] <= cnt[k_cur] + 1'b1;
      end
    end
  end

  // Event queue and overflow flag
  keypad_event_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_vld),
    .push_data (push_ev),
    .pop       (key_ready),
    .head      (head_ev),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dropped   = push_vld && fifo_full && !key_ready;
  assign key_valid = !fifo_empty;
  assign key_code  = head_ev.code[KW-1:0];
  assign key_press = head_ev.press;
  // Code bits above KW are always zero.
  assign unused_head_hi = ^head_ev.code;

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset)             overflow <= 1'b0;
    else if (dropped)      overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
module tb_keypad_matrix_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SD   = 16;
  localparam int DEB  = 3;
  localparam int FD   = 4;
  localparam int NK   = ROWS*COLS;
  localparam int KW   = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            key_valid;
  logic            key_ready = 1'b1;
  logic [KW-1:0]   key_code;
  logic            key_press;
  logic [NK-1:0]   key_state;
  logic            overflow;
  logic            overflow_clr = 1'b0;
  logic [NK-1:0]   keys = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB), .FIFO_DEPTH(FD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .row          (row),
    .col          (col),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_code     (key_code),
    .key_press    (key_press),
    .key_state    (key_state),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Physical keypad: a pressed key connects its row line to its column line.
  always_comb begin
    col = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row[r] && keys[r*COLS+c]) col[c] = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in cycles since reset release (m). Row s of the frame
  // sequence is sampled at the end of cycle (s+1)*SD; its column c is judged
  // c+1 cycles later. Debounce is tracked as a run length of differing samples.
  typedef struct { int code; bit press; } ev_t;

  int            m = 0;
  bit [NK-1:0]   mstate = '0;
  int            run [NK];
  bit [COLS-1:0] samp = '0;
  int            srow = 0;
  ev_t           q [$];
  ev_t           last = '{0, 1'b0};
  bit            mov = 1'b0;
  bit            started = 1'b0;

  function automatic bit push_due();
    int ph, k;
    if (m < SD) return 1'b0;
    ph = m % SD;
    if (ph < 1 || ph > COLS) return 1'b0;
    k = srow*COLS + ph - 1;
    return (samp[ph-1] != mstate[k]) && (run[k] + 1 == DEB);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m = 0;
      mstate = '0;
      for (int i = 0; i < NK; i++) run[i] = 0;
      q.delete();
      last = '{0, 1'b0};
      mov = 1'b0;
      started = 1'b1;
    end else begin
      int ph, k;
      bit due, drop;
      ev_t e;
      drop = 1'b0;
      due = push_due();
      if (q.size() > 0 && key_ready) last = q.pop_front();
      ph = m % SD;
      if (m >= SD && ph == 0) begin
        srow = (m/SD - 1) % ROWS;
        for (int c = 0; c < COLS; c++) samp[c] = keys[srow*COLS+c];
      end else if (m >= SD && ph >= 1 && ph <= COLS) begin
        k = srow*COLS + ph - 1;
        if (samp[ph-1] == mstate[k]) run[k] = 0;
        else if (due) begin
          mstate[k] = samp[ph-1];
          run[k] = 0;
          e.code = k;
          e.press = samp[ph-1];
          if (q.size() < FD) q.push_back(e);
          else drop = 1'b1;
        end else run[k]++;
      end
      if (overflow_clr) mov = 1'b0;
      if (drop) mov = 1'b1;
      m++;
    end
  end

  // Compare process: every cycle after the first reset
  always @(negedge clock) begin
    if (started) begin
      int adv;
      ev_t h;
      adv = (m >= SD + COLS + 2) ? (m - (COLS + 2)) / SD : 0;
      if (q.size() > 0) h = q[0];
      else h = last;
      chk("row", row, 64'(1) << (adv % ROWS));
      chk("key_valid", key_valid, (q.size() > 0));
      chk("key_code", key_code, h.code);
      chk("key_press", key_press, h.press);
      chk("key_state", key_state, mstate);
      chk("overflow", overflow, mov);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int bound);
    int n;
    n = 0;
    while (!key_valid && n < bound) begin
      @(negedge clock);
      n++;
    end
    if (!key_valid) chk({nm, "_timeout"}, key_valid, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_row"}, row, 4'b0001);
    chk({nm, "_valid"}, key_valid, 0);
    chk({nm, "_code"}, key_code, 0);
    chk({nm, "_press"}, key_press, 0);
    chk({nm, "_state"}, key_state, 0);
    chk({nm, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int n;
    // Hold row2/col1 (code 9) from reset
    keys = '0;
    keys[9] = 1'b1;
    do_reset();
    check_reset_outputs("rst");
    wait_valid("press9", 400);
    chk("press9_cycle", m, 179);
    chk("press9_code", key_code, 9);
    chk("press9_type", key_press, 1);
    chk("press9_state", key_state[9], 1);
    keys = '0;
    @(negedge clock);
    wait_valid("rel9", 400);
    chk("rel9_code", key_code, 9);
    chk("rel9_type", key_press, 0);
    chk("rel9_state", key_state[9], 0);

    // Bounce key 0 for two samples only
    do_reset();
    keys[0] = 1'b1;
    n = 0;
    repeat (2*ROWS*SD) begin
      @(negedge clock);
      if (key_valid) n++;
    end
    keys = '0;
    repeat (6*ROWS*SD) begin
      @(negedge clock);
      if (key_valid) n++;
    end
    chk("bounce_events", n, 0);
    chk("bounce_state", key_state, 0);

    // Two keys in row 1
    do_reset();
    keys[4] = 1'b1;
    keys[7] = 1'b1;
    wait_valid("roll4", 400);
    chk("roll4_cycle", m, 162);
    chk("roll4_code", key_code, 4);
    @(negedge clock);
    wait_valid("roll7", 50);
    chk("roll7_cycle", m, 165);
    chk("roll7_code", key_code, 7);

    // Overflow: five presses with the consumer stalled
    key_ready = 1'b0;
    keys = '0;
    do_reset();
    keys[0] = 1'b1; keys[1] = 1'b1; keys[2] = 1'b1; keys[3] = 1'b1; keys[5] = 1'b1;
    while (m < 170) @(negedge clock);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", key_valid, 1);
    overflow_clr = 1'b1;
    @(negedge clock);
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", key_valid, 1);
      chk("drain_code", key_code, i);
      @(negedge clock);
    end
    chk("drain_empty", key_valid, 0);

    // Full FIFO: push and pop in the same cycle
    key_ready = 1'b0;
    keys = '0;
    do_reset();
    keys[3:0] = 4'hf;
    n = 0;
    while (q.size() < FD && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("full_valid", key_valid, 1);
    keys[4] = 1'b1;
    n = 0;
    while (!push_due() && n < 600) begin
      @(negedge clock);
      n++;
    end
    chk("full_push_cycle", m, 289);
    key_ready = 1'b1;
    @(negedge clock);
    key_ready = 1'b0;
    chk("full_no_ovf", overflow, 0);
    key_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("full_order", key_code, i);
      @(negedge clock);
    end

    // Reset in the middle of a COMMIT with key 5 held
    keys = '0;
    do_reset();
    keys[5] = 1'b1;
    wait_valid("k5", 400);
    chk("k5_code", key_code, 5);
    while (!(m > 200 && m % SD == 2)) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("midrst");
    wait_valid("k5again", 400);
    chk("k5again_cycle", m, 163);
    chk("k5again_code", key_code, 5);
    chk("k5again_type", key_press, 1);

    // Randomised traffic
    keys = '0;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      keys = NK'($urandom & $urandom & $urandom);
      repeat ($urandom_range(20, 300)) begin
        @(negedge clock);
        key_ready    = ($urandom_range(0, 3) != 0);
        overflow_clr = ($urandom_range(0, 19) == 0);
      end
    end
    key_ready = 1'b1;
    overflow_clr = 1'b0;
    repeat (10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
